decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Parametrised instruction-decode stage for the MIPS/DLX pipeline, sitting between the IF/ID latch and the EX stage. It reads the register file with write-first bypass, resolves BEQ/BNE/J in ID with forwarded operands, detects load-use hazards with a configurable stall length, and holds a valid/ready-handshaked ID/EX output register. Unlike the previous decode stage, it has back-pressure from EX, a sticky halt, and a multi-cycle load-use stall.

## Interface
- NB_DATA, 32, datapath width (≥16)
- NB_ADDR, 10, PC / branch-target width (≤16)
- NB_REG, 5, register index width; register file holds 2^NB_REG entries
- LOAD_USE_STALL, 1, bubbles inserted per load-use hazard (1..7)
- NB_EX_CTRL / NB_MEM_CTRL / NB_WB_CTRL, 7 / 6 / 3, control bundle widths
- i_clock  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clock
- i_valid  in  1  IF/ID holds a valid instruction
- o_ready  out  1  stage accepts the instruction this cycle
- i_instruction  in  32  opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0]
- i_pc  in  NB_ADDR  PC+1 of the instruction (word addressed)
- i_ctrl_ex / i_ctrl_mem / i_ctrl_wb  in  ctrl widths  control-unit decode of i_instruction
- i_is_beq, i_is_bne, i_is_jump, i_is_halt, i_imm_zext  in  1 each  control-unit class flags
- i_wb_we  in  1; i_wb_addr  in  NB_REG; i_wb_data  in  NB_DATA  write-back port
- i_ex_mem_read  in  1; i_ex_rt  in  NB_REG  load currently in EX
- i_fwd_a, i_fwd_b  in  1; i_fwd_data  in  NB_DATA  EX/MEM forward for branch compare
- i_ready  in  1  EX accepts the ID/EX register
- o_valid  out  1  ID/EX register holds an instruction
- o_rs, o_rt, o_rd, o_shamt  out  NB_REG; o_funct  out  6
- o_data_a, o_data_b, o_imm_ext  out  NB_DATA
- o_ctrl_ex / o_ctrl_mem / o_ctrl_wb  out  ctrl widths
- o_redirect  out  1; o_redirect_pc  out  NB_ADDR  taken branch/jump
- o_halt  out  1  sticky halt

## Operation
- advance = i_ready | ~o_valid; accept = i_valid & o_ready.
- hazard = i_valid & i_ex_mem_read & (i_ex_rt ≠ 0) & (i_ex_rt == rs | i_ex_rt == rt).
- Stall counter cnt (3 bits): when cnt == 0 and hazard and advance, load LOAD_USE_STALL−1 and present a bubble. While cnt > 0, decrement each advance cycle and present a bubble. A bubble clears o_valid and the ctrl outputs.
- o_ready = ~i_reset & ~halted & advance & ~hazard & (cnt == 0).
- On accept the ID/EX register loads the fields, read data, extended immediate (sign-extended, or zero-extended when i_imm_zext) and ctrl. On advance without accept, o_valid goes to 0. Otherwise the register holds.
- Register file: entry 0 reads 0 and ignores writes. A write to rs/rt in the same cycle bypasses into the read (write-first).
- Branch: A = i_fwd_a ? i_fwd_data : rf[rs]; B likewise. taken = accept & ((i_is_beq & A==B) | (i_is_bne & A≠B) | i_is_jump). Target = i_pc + imm[NB_ADDR-1:0] for branches; instruction[NB_ADDR-1:0] for jumps. Addition wraps modulo 2^NB_ADDR.
- Halt: accepting an instruction with i_is_halt sets halted. The halt enters ID/EX with zeroed ctrl. halted forces o_ready=0 until reset.

## Timing
- Reset clears all registers. Outputs during and after reset: o_valid 0, ctrl 0, fields/data 0, o_halt 0, o_redirect 0, o_ready 0. o_ready is 1 from the first cycle after reset.
- Latency: one cycle from accept to o_valid.
- o_redirect and o_redirect_pc are combinational in the accept cycle. IF flushes on o_redirect.
- Back-pressure: while ~i_ready & o_valid, all outputs hold stable.
- A hazard plus i_ready=0 does not start the counter until advance.
- Reset mid-stall clears cnt and halted.
- Write-back proceeds during stalls and halt.

## Configuration
- DECODE_DEBUG_PORT_EN defined: adds i_dbg_addr (in, NB_REG) and o_dbg_data (out, NB_DATA). o_dbg_data is a combinational third read port with no pipeline effect.
- Undefined: those ports and the third read port do not exist.

## Structure
- mips_pkg: instruction field bit ranges, ctrl widths, opcode constants.
- Sub-module regfile_bypass: 2^NB_REG × NB_DATA, two read ports, one write port, write-first, r0 zero, optional debug port.

## Test plan
- ADD r3,r1,r2 with r1=5, r2=7 preloaded, i_ready=1 → next cycle o_valid=1, o_data_a=5, o_data_b=7, o_rd=3.
- LW r4 in EX (i_ex_mem_read=1, i_ex_rt=4), ID holds ADD using r4, LOAD_USE_STALL=2 → o_ready=0 for 2 cycles, 2 bubbles, then accept.
- BEQ r1,r1,imm=+4, i_pc=10 → o_redirect=1, o_redirect_pc=14 in the accept cycle. With i_fwd_a=1 and i_fwd_data≠r1 → no redirect.
- i_ready=0 for 3 cycles with o_valid=1 → outputs stable and o_ready=0; the instruction is accepted the cycle i_ready returns.
- HALT accepted → o_halt=1 and o_ready=0 permanently; i_reset → all outputs 0 and o_ready=1 the cycle after.
- Write r5=9 and read r5 in the same cycle → o_data_a=9 next cycle. Write to r0 → r0 still reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS/DLX decode definitions: instruction field positions, control widths, opcodes.
package mips_pkg;

    localparam int NB_INSTR  = 32;
    localparam int NB_IMM    = 16;
    localparam int NB_FUNCT  = 6;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    localparam int NB_EX_CTRL_DEF  = 7;
    localparam int NB_MEM_CTRL_DEF = 6;
    localparam int NB_WB_CTRL_DEF  = 3;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0d,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b,
        OP_HALT  = 6'h3f
    } opcode_e;

endpackage

// File: rtl/regfile_bypass.sv
// 2^NB_REG x NB_DATA register file: two write-first read ports, one write port, r0 hard zero.
// DECODE_DEBUG_PORT_EN adds a third combinational read port for debug.
module regfile_bypass
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_REG-1:0]  i_rs_addr,
    input  logic [NB_REG-1:0]  i_rt_addr,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    input  logic               i_we,
    input  logic [NB_REG-1:0]  i_waddr,
    input  logic [NB_DATA-1:0] i_wdata
`ifdef DECODE_DEBUG_PORT_EN
    ,
    input  logic [NB_REG-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data
`endif
);

    localparam int N_ENTRIES = 2 ** NB_REG;

    logic [NB_DATA-1:0] mem [N_ENTRIES];

    // NOTE: the array is flop-based and the stage guarantees an all-zero state after reset,
    // so it is cleared here; a RAM macro would not allow this.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first: a same-cycle write to the read address is returned instead of the stale entry.
    assign o_rs_data = (i_rs_addr == '0)                ? '0      :
                       (i_we && (i_waddr == i_rs_addr)) ? i_wdata : mem[i_rs_addr];
    assign o_rt_data = (i_rt_addr == '0)                ? '0      :
                       (i_we && (i_waddr == i_rt_addr)) ? i_wdata : mem[i_rt_addr];

`ifdef DECODE_DEBUG_PORT_EN
    assign o_dbg_data = (i_dbg_addr == '0)                ? '0      :
                        (i_we && (i_waddr == i_dbg_addr)) ? i_wdata : mem[i_dbg_addr];
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: register read, branch resolution, load-use stall, handshaked ID/EX register, sticky halt.
// DECODE_DEBUG_PORT_EN adds i_dbg_addr/o_dbg_data (register file debug read).
module decode_stage_pipe
    import mips_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 10,
    parameter int NB_REG         = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int NB_EX_CTRL     = NB_EX_CTRL_DEF,
    parameter int NB_MEM_CTRL    = NB_MEM_CTRL_DEF,
    parameter int NB_WB_CTRL     = NB_WB_CTRL_DEF
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NB_INSTR-1:0]    i_instruction,
    input  logic [NB_ADDR-1:0]     i_pc,
    input  logic [NB_EX_CTRL-1:0]  i_ctrl_ex,
    input  logic [NB_MEM_CTRL-1:0] i_ctrl_mem,
    input  logic [NB_WB_CTRL-1:0]  i_ctrl_wb,
    input  logic                   i_is_beq,
    input  logic                   i_is_bne,
    input  logic                   i_is_jump,
    input  logic                   i_is_halt,
    input  logic                   i_imm_zext,
    input  logic                   i_wb_we,
    input  logic [NB_REG-1:0]      i_wb_addr,
    input  logic [NB_DATA-1:0]     i_wb_data,
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG-1:0]      i_ex_rt,
    input  logic                   i_fwd_a,
    input  logic                   i_fwd_b,
    input  logic [NB_DATA-1:0]     i_fwd_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [NB_REG-1:0]      o_rs,
    output logic [NB_REG-1:0]      o_rt,
    output logic [NB_REG-1:0]      o_rd,
    output logic [NB_REG-1:0]      o_shamt,
    output logic [NB_FUNCT-1:0]    o_funct,
    output logic [NB_DATA-1:0]     o_data_a,
    output logic [NB_DATA-1:0]     o_data_b,
    output logic [NB_DATA-1:0]     o_imm_ext,
    output logic [NB_EX_CTRL-1:0]  o_ctrl_ex,
    output logic [NB_MEM_CTRL-1:0] o_ctrl_mem,
    output logic [NB_WB_CTRL-1:0]  o_ctrl_wb,
    output logic                   o_redirect,
    output logic [NB_ADDR-1:0]     o_redirect_pc,
    output logic                   o_halt
`ifdef DECODE_DEBUG_PORT_EN
    ,
    input  logic [NB_REG-1:0]      i_dbg_addr,
    output logic [NB_DATA-1:0]     o_dbg_data
`endif
);

    localparam logic [2:0] STALL_LOAD = 3'(LOAD_USE_STALL - 1);

    logic [NB_REG-1:0]  rs, rt, rd, shamt;
    logic [NB_IMM-1:0]  imm;
    logic [NB_DATA-1:0] rs_data, rt_data, op_a, op_b, imm_ext;
    logic [NB_ADDR-1:0] target;
    logic [2:0]         cnt;
    logic               halted, advance, accept, hazard, taken;
    logic               unused_opcode;

    assign rs    = NB_REG'(i_instruction[RS_HI:RS_LO]);
    assign rt    = NB_REG'(i_instruction[RT_HI:RT_LO]);
    assign rd    = NB_REG'(i_instruction[RD_HI:RD_LO]);
    assign shamt = NB_REG'(i_instruction[SHAMT_HI:SHAMT_LO]);
    assign imm   = i_instruction[IMM_HI:IMM_LO];
    // The opcode is already decoded into the class flags and ctrl bundles upstream.
    assign unused_opcode = ^i_instruction[OPCODE_HI:OPCODE_LO];

    regfile_bypass #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG)
    ) u_regfile (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_rs_addr (rs),
        .i_rt_addr (rt),
        .o_rs_data (rs_data),
        .o_rt_data (rt_data),
        .i_we      (i_wb_we),
        .i_waddr   (i_wb_addr),
        .i_wdata   (i_wb_data)
`ifdef DECODE_DEBUG_PORT_EN
        ,
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
`endif
    );

    assign advance = i_ready | ~o_valid;
    assign hazard  = i_valid & i_ex_mem_read & (i_ex_rt != '0) & ((i_ex_rt == rs) | (i_ex_rt == rt));
    assign o_ready = ~i_reset & ~halted & advance & ~hazard & (cnt == 3'd0);
    assign accept  = i_valid & o_ready;

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        imm_ext        = {NB_DATA{~i_imm_zext & imm[NB_IMM-1]}};
        imm_ext[15:0]  = imm;
    end

    // Branch compare sees EX/MEM results through the forward path, not just the register file.
    assign op_a   = i_fwd_a ? i_fwd_data : rs_data;
    assign op_b   = i_fwd_b ? i_fwd_data : rt_data;
    assign taken  = accept & ((i_is_beq & (op_a == op_b)) | (i_is_bne & (op_a != op_b)) | i_is_jump);
    assign target = i_is_jump ? i_instruction[NB_ADDR-1:0] : i_pc + imm[NB_ADDR-1:0];

    assign o_redirect    = taken;
    assign o_redirect_pc = taken ? target : '0;
    assign o_halt        = halted;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt        <= 3'd0;
            halted     <= 1'b0;
            o_valid    <= 1'b0;
            o_rs       <= '0;
            o_rt       <= '0;
            o_rd       <= '0;
            o_shamt    <= '0;
            o_funct    <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_imm_ext  <= '0;
            o_ctrl_ex  <= '0;
            o_ctrl_mem <= '0;
            o_ctrl_wb  <= '0;
        end else begin
            if (accept && i_is_halt) begin
                halted <= 1'b1;
            end
            // The counter only moves on advance so back-pressure stretches, never shortens, the stall.
            if (cnt != 3'd0) begin
                if (advance) begin
                    cnt <= cnt - 3'd1;
                end
            end else if (hazard && advance) begin
                cnt <= STALL_LOAD;
            end

            if (accept) begin
                o_valid    <= 1'b1;
                o_rs       <= rs;
                o_rt       <= rt;
                o_rd       <= rd;
                o_shamt    <= shamt;
                o_funct    <= i_instruction[FUNCT_HI:FUNCT_LO];
                o_data_a   <= rs_data;
                o_data_b   <= rt_data;
                o_imm_ext  <= imm_ext;
                o_ctrl_ex  <= i_is_halt ? '0 : i_ctrl_ex;
                o_ctrl_mem <= i_is_halt ? '0 : i_ctrl_mem;
                o_ctrl_wb  <= i_is_halt ? '0 : i_ctrl_wb;
            end else if (advance) begin
                o_valid    <= 1'b0;
                o_ctrl_ex  <= '0;
                o_ctrl_mem <= '0;
                o_ctrl_wb  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed handshake/stall/branch/halt checks plus an ID/EX scoreboard.
module tb_decode_stage_pipe;
    import mips_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 10;
    localparam int NB_REG  = 5;
    localparam int STALL   = 2;
    localparam int NB_EX   = 7;
    localparam int NB_MEM  = 6;
    localparam int NB_WB   = 3;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_valid, o_ready;
    logic [31:0]        i_instruction;
    logic [NB_ADDR-1:0] i_pc;
    logic [NB_EX-1:0]   i_ctrl_ex;
    logic [NB_MEM-1:0]  i_ctrl_mem;
    logic [NB_WB-1:0]   i_ctrl_wb;
    logic               i_is_beq, i_is_bne, i_is_jump, i_is_halt, i_imm_zext;
    logic               i_wb_we;
    logic [NB_REG-1:0]  i_wb_addr;
    logic [NB_DATA-1:0] i_wb_data;
    logic               i_ex_mem_read;
    logic [NB_REG-1:0]  i_ex_rt;
    logic               i_fwd_a, i_fwd_b;
    logic [NB_DATA-1:0] i_fwd_data;
    logic               i_ready;
    logic               o_valid;
    logic [NB_REG-1:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]         o_funct;
    logic [NB_DATA-1:0] o_data_a, o_data_b, o_imm_ext;
    logic [NB_EX-1:0]   o_ctrl_ex;
    logic [NB_MEM-1:0]  o_ctrl_mem;
    logic [NB_WB-1:0]   o_ctrl_wb;
    logic               o_redirect;
    logic [NB_ADDR-1:0] o_redirect_pc;
    logic               o_halt;
`ifdef DECODE_DEBUG_PORT_EN
    logic [NB_REG-1:0]  i_dbg_addr = '0;
    logic [NB_DATA-1:0] o_dbg_data;
`endif

    always #5 i_clock = ~i_clock;

    decode_stage_pipe #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG), .LOAD_USE_STALL(STALL),
        .NB_EX_CTRL(NB_EX), .NB_MEM_CTRL(NB_MEM), .NB_WB_CTRL(NB_WB)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pc(i_pc),
        .i_ctrl_ex(i_ctrl_ex), .i_ctrl_mem(i_ctrl_mem), .i_ctrl_wb(i_ctrl_wb),
        .i_is_beq(i_is_beq), .i_is_bne(i_is_bne), .i_is_jump(i_is_jump),
        .i_is_halt(i_is_halt), .i_imm_zext(i_imm_zext),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
        .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_fwd_data(i_fwd_data),
        .i_ready(i_ready), .o_valid(o_valid),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_imm_ext(o_imm_ext),
        .o_ctrl_ex(o_ctrl_ex), .o_ctrl_mem(o_ctrl_mem), .o_ctrl_wb(o_ctrl_wb),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_halt(o_halt)
`ifdef DECODE_DEBUG_PORT_EN
        ,
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
`endif
    );

    typedef struct {
        logic [NB_DATA-1:0] a, b, imm;
        logic [NB_REG-1:0]  rs, rt, rd;
        logic [5:0]         funct;
        logic [NB_EX-1:0]   ex;
        logic [NB_MEM-1:0]  mem;
        logic [NB_WB-1:0]   wb;
    } exp_t;

    exp_t               sb[$];
    logic [NB_DATA-1:0] model [32];
    int                 total = 0;
    int                 bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] model_read(input logic [NB_REG-1:0] a);
        if (a == '0) return '0;
        if (i_wb_we && (i_wb_addr == a)) return i_wb_data;
        return model[a];
    endfunction

    // Scoreboard: expected ID/EX contents captured at each accepting edge, compared once registered.
    always @(posedge i_clock) begin
        exp_t e;
        logic acc;
        acc = 1'b0;
        if (i_reset) begin
            foreach (model[k]) model[k] = '0;
            sb.delete();
        end else begin
            acc = i_valid && o_ready;
            if (acc) begin
                e.rs    = i_instruction[25:21];
                e.rt    = i_instruction[20:16];
                e.rd    = i_instruction[15:11];
                e.funct = i_instruction[5:0];
                e.a     = model_read(e.rs);
                e.b     = model_read(e.rt);
                e.imm   = i_imm_zext ? {16'h0, i_instruction[15:0]}
                                     : {{16{i_instruction[15]}}, i_instruction[15:0]};
                e.ex    = i_is_halt ? '0 : i_ctrl_ex;
                e.mem   = i_is_halt ? '0 : i_ctrl_mem;
                e.wb    = i_is_halt ? '0 : i_ctrl_wb;
                sb.push_back(e);
            end
            if (i_wb_we && (i_wb_addr != '0)) model[i_wb_addr] = i_wb_data;
        end
        #1;
        if (acc) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_valid", o_valid, 1);
                check("sb_data_a", o_data_a, e.a);
                check("sb_data_b", o_data_b, e.b);
                check("sb_rs", o_rs, e.rs);
                check("sb_rt", o_rt, e.rt);
                check("sb_rd", o_rd, e.rd);
                check("sb_funct", o_funct, e.funct);
                check("sb_imm", o_imm_ext, e.imm);
                check("sb_ctrl_ex", o_ctrl_ex, e.ex);
                check("sb_ctrl_mem", o_ctrl_mem, e.mem);
                check("sb_ctrl_wb", o_ctrl_wb, e.wb);
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_instruction = '0; i_pc = '0;
        i_ctrl_ex = 7'h2a; i_ctrl_mem = 6'h15; i_ctrl_wb = 3'h5;
        i_is_beq = 0; i_is_bne = 0; i_is_jump = 0; i_is_halt = 0; i_imm_zext = 0;
        i_wb_we = 0; i_wb_addr = '0; i_wb_data = '0;
        i_ex_mem_read = 0; i_ex_rt = '0;
        i_fwd_a = 0; i_fwd_b = 0; i_fwd_data = '0;
        i_ready = 1;
    endtask

    task automatic write_reg(input logic [NB_REG-1:0] a, input logic [NB_DATA-1:0] d);
        i_wb_we = 1; i_wb_addr = a; i_wb_data = d;
        tick();
        i_wb_we = 0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [NB_ADDR-1:0] pc);
        i_valid = 1; i_instruction = instr; i_pc = pc;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'(OP_RTYPE), rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input opcode_e op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {6'(op), rs, rt, imm};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        i_reset = 1;
        drive(rtype(1, 2, 3), 1);
        tick(); tick();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_halt", o_halt, 0);
        check("rst_redirect", o_redirect, 0);
        check("rst_ctrl_ex", o_ctrl_ex, 0);
        check("rst_data_a", o_data_a, 0);
        i_valid = 0;
        i_reset = 0;
        settle();
        check("ready_after_rst", o_ready, 1);

        write_reg(1, 5); write_reg(2, 7); write_reg(4, 11); write_reg(0, 123);

        // ADD r3,r1,r2
        drive(rtype(1, 2, 3), 1);
        settle();
        check("add_ready", o_ready, 1);
        check("add_no_redirect", o_redirect, 0);
        tick();
        check("add_rd", o_rd, 3);
        check("add_data_a", o_data_a, 5);
        check("add_data_b", o_data_b, 7);
        i_valid = 0;
        tick();
        check("bubble_valid", o_valid, 0);
        check("bubble_ctrl_ex", o_ctrl_ex, 0);

        // r0 ignores writes; write-first bypass
        drive(rtype(0, 1, 6), 2);
        tick();
        check("r0_reads_zero", o_data_a, 0);
        i_wb_we = 1; i_wb_addr = 5; i_wb_data = 9;
        drive(rtype(5, 0, 7), 3);
        tick();
        check("write_first", o_data_a, 9);
        i_wb_we = 0;

        // load in EX targeting r0 is not a hazard
        i_ex_mem_read = 1; i_ex_rt = 0;
        drive(rtype(0, 1, 8), 4);
        settle();
        check("no_hazard_r0", o_ready, 1);
        tick();

        // load-use on r4: two bubbles with LOAD_USE_STALL=2
        i_ex_rt = 4;
        drive(rtype(4, 1, 8), 5);
        settle();
        check("lu_ready_c0", o_ready, 0);
        tick();
        check("lu_bubble1_valid", o_valid, 0);
        check("lu_bubble1_ctrl", o_ctrl_ex, 0);
        i_ex_mem_read = 0;
        settle();
        check("lu_ready_c1", o_ready, 0);
        tick();
        check("lu_bubble2_valid", o_valid, 0);
        settle();
        check("lu_ready_c2", o_ready, 1);
        tick();
        check("lu_accept_data_a", o_data_a, 11);

        // branches and jump
        i_is_beq = 1;
        i_valid = 0;
        drive(itype(OP_BEQ, 1, 1, 16'd4), 10);
        i_valid = 0;
        settle();
        check("beq_invalid_no_redirect", o_redirect, 0);
        i_valid = 1;
        settle();
        check("beq_redirect", o_redirect, 1);
        check("beq_target", o_redirect_pc, 14);
        tick();
        i_fwd_a = 1; i_fwd_data = 99;
        settle();
        check("beq_fwd_no_redirect", o_redirect, 0);
        tick();
        i_fwd_a = 0; i_is_beq = 0;
        i_is_bne = 1;
        drive(itype(OP_BNE, 1, 2, 16'hfffd), 2);
        settle();
        check("bne_redirect", o_redirect, 1);
        check("bne_target_wrap", o_redirect_pc, 10'h3ff);
        tick();
        i_is_bne = 0;
        i_is_jump = 1;
        drive({6'(OP_J), 26'h00002ab}, 7);
        settle();
        check("jump_redirect", o_redirect, 1);
        check("jump_target", o_redirect_pc, 10'h2ab);
        tick();
        i_is_jump = 0;
        i_imm_zext = 1;
        drive(itype(OP_ORI, 1, 9, 16'h8001), 8);
        tick();
        check("zext_imm", o_imm_ext, 32'h0000_8001);
        i_imm_zext = 0;

        // back-pressure for three cycles
        drive(rtype(1, 2, 9), 11);
        tick();
        i_ready = 0;
        drive(rtype(2, 1, 10), 12);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_ready", o_ready, 0);
            tick();
            check("bp_hold_valid", o_valid, 1);
            check("bp_hold_rd", o_rd, 9);
            check("bp_hold_data_a", o_data_a, 5);
        end
        i_ready = 1;
        settle();
        check("bp_release_ready", o_ready, 1);
        tick();
        check("bp_new_rd", o_rd, 10);

        // hazard under back-pressure: counter must not start until advance
        i_ready = 0; i_ex_mem_read = 1; i_ex_rt = 4;
        drive(rtype(4, 2, 13), 13);
        tick(); tick();
        check("hz_bp_hold_rd", o_rd, 10);
        i_ready = 1;
        settle();
        check("hz_bp_ready_c0", o_ready, 0);
        tick();
        i_ex_mem_read = 0;
        settle();
        check("hz_bp_ready_c1", o_ready, 0);
        tick();
        settle();
        check("hz_bp_release", o_ready, 1);
        tick();
        check("hz_bp_rd", o_rd, 13);

        // sticky halt
        i_is_halt = 1; i_ctrl_ex = 7'h7f;
        drive({6'(OP_HALT), 26'h0}, 14);
        tick();
        check("halt_flag", o_halt, 1);
        check("halt_valid", o_valid, 1);
        check("halt_ctrl_ex", o_ctrl_ex, 0);
        i_is_halt = 0; i_ctrl_ex = 7'h2a;
        drive(rtype(1, 2, 15), 15);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("halt_ready", o_ready, 0);
            tick();
        end
        check("halt_sticky", o_halt, 1);

        // reset clears everything, including the register file
        i_reset = 1;
        tick();
        check("rst2_valid", o_valid, 0);
        check("rst2_halt", o_halt, 0);
        check("rst2_ctrl_wb", o_ctrl_wb, 0);
        check("rst2_rd", o_rd, 0);
        check("rst2_ready", o_ready, 0);
        check("rst2_redirect", o_redirect, 0);
        i_reset = 0;
        settle();
        check("ready_after_rst2", o_ready, 1);
        tick();
        check("rf_cleared", o_data_a, 0);

        idle_inputs();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
